// File: rtl/rans_decoder.sv
// Streaming rANS decoder: loads the initial state, then decodes symbols with word renormalisation.
// Optional define RANS_DEC_FINAL_CHECK_EN flags an error when the final state is not L.
//
// state   | meaning
// IDLE    | waiting for start; tables writable
// LOAD    | shifting in the initial state words
// DECODE  | table lookup and next-state computation
// EMIT    | presenting sym_out until accepted
// RENORM  | shifting words in while the state is below L
// FIN     | done pulse
// ERR     | error raised, job aborted
module rans_decoder #(
    parameter int SYMBOL_WIDTH = 4,
    parameter int NUM_SYMBOLS  = 16,
    parameter int LOG_M        = 10,
    parameter int STATE_WIDTH  = 32,
    parameter int IO_WIDTH     = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    config_en,
    input  logic [SYMBOL_WIDTH-1:0] config_select,
    input  logic [LOG_M:0]          config_freq,
    input  logic [LOG_M-1:0]        config_cumul,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  num_syms,
    input  logic [IO_WIDTH-1:0]     in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SYMBOL_WIDTH-1:0] sym_out,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic [STATE_WIDTH-1:0]  state_out,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int NWORDS = STATE_WIDTH / IO_WIDTH;
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam logic [STATE_WIDTH-1:0] L_BOUND = STATE_WIDTH'(1) << (STATE_WIDTH - IO_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DECODE, S_EMIT, S_RENORM, S_FIN, S_ERR
    } fsm_t;

    fsm_t                    fsm_q, fsm_d;
    logic [STATE_WIDTH-1:0]  rans_q, rans_d;
    logic [STATE_WIDTH-1:0]  next_q, next_d;
    logic [SYMBOL_WIDTH-1:0] sym_q, sym_d;
    logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic                    err_q, err_d;
    logic [LOG_M:0]          freq_q  [NUM_SYMBOLS];
    logic [LOG_M:0]          freq_d  [NUM_SYMBOLS];
    logic [LOG_M-1:0]        cumul_q [NUM_SYMBOLS];
    logic [LOG_M-1:0]        cumul_d [NUM_SYMBOLS];

    logic [LOG_M-1:0]        slot;
    logic                    hit;
    logic [SYMBOL_WIDTH-1:0] hit_idx;
    logic [STATE_WIDTH-1:0]  dec_next;
    logic [STATE_WIDTH-1:0]  shifted;
    logic [COUNT_WIDTH-1:0]  rem_dec;

    assign slot    = rans_q[LOG_M-1:0];
    assign shifted = {rans_q[STATE_WIDTH-IO_WIDTH-1:0], in_data};
    assign rem_dec = rem_q - COUNT_WIDTH'(1);

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SYMBOLS - 1; i >= 0; i--) begin
            if (freq_q[i] != '0 &&
                {2'b00, cumul_q[i]} <= {2'b00, slot} &&
                {2'b00, slot} < ({2'b00, cumul_q[i]} + {1'b0, freq_q[i]})) begin
                hit     = 1'b1;
                hit_idx = SYMBOL_WIDTH'(i);
            end
        end
        dec_next = STATE_WIDTH'(freq_q[hit_idx]) * (rans_q >> LOG_M)
                 + STATE_WIDTH'(slot) - STATE_WIDTH'(cumul_q[hit_idx]);
    end

    always_comb begin
        fsm_d   = fsm_q;
        rans_d  = rans_q;
        next_d  = next_q;
        sym_d   = sym_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        freq_d  = freq_q;
        cumul_d = cumul_q;
        case (fsm_q)
            S_IDLE: begin
                if (config_en) begin
                    freq_d[config_select]  = config_freq;
                    cumul_d[config_select] = config_cumul;
                end
                if (start) begin
                    fsm_d  = S_LOAD;
                    rem_d  = num_syms;
                    err_d  = 1'b0;
                    wcnt_d = WCNT_W'(NWORDS - 1);
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    rans_d = shifted;
                    wcnt_d = wcnt_q - WCNT_W'(1);
                    if (wcnt_q == '0) begin
                        if (shifted < L_BOUND) begin
                            fsm_d = S_ERR;
                            err_d = 1'b1;
                        end else begin
                            fsm_d = (rem_q == '0) ? S_FIN : S_DECODE;
                        end
                    end
                end
            end
            S_DECODE: begin
                if (hit) begin
                    sym_d  = hit_idx;
                    next_d = dec_next;
                    fsm_d  = S_EMIT;
                end else begin
                    fsm_d = S_ERR;
                    err_d = 1'b1;
                end
            end
            S_EMIT: begin
                if (sym_ready) begin
                    rans_d = next_q;
                    rem_d  = rem_dec;
                    if (next_q < L_BOUND)  fsm_d = S_RENORM;
                    else if (rem_dec == '0) fsm_d = S_FIN;
                    else                    fsm_d = S_DECODE;
                end
            end
            S_RENORM: begin
                if (in_valid) begin
                    rans_d = shifted;
                    if (shifted >= L_BOUND)
                        fsm_d = (rem_q == '0) ? S_FIN : S_DECODE;
                end
            end
            S_FIN: begin
                fsm_d = S_IDLE;
`ifdef RANS_DEC_FINAL_CHECK_EN
                if (rans_q != L_BOUND) err_d = 1'b1;
`endif
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            rans_q <= '0;
            next_q <= '0;
            sym_q  <= '0;
            rem_q  <= '0;
            wcnt_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_SYMBOLS; i++) begin
                freq_q[i]  <= '0;
                cumul_q[i] <= '0;
            end
        end else begin
            fsm_q   <= fsm_d;
            rans_q  <= rans_d;
            next_q  <= next_d;
            sym_q   <= sym_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            freq_q  <= freq_d;
            cumul_q <= cumul_d;
        end
    end

    assign in_ready  = (fsm_q == S_LOAD) || (fsm_q == S_RENORM);
    assign sym_valid = (fsm_q == S_EMIT);
    assign busy      = (fsm_q == S_LOAD) || (fsm_q == S_DECODE) ||
                       (fsm_q == S_EMIT) || (fsm_q == S_RENORM);
    assign done      = (fsm_q == S_FIN);
    assign sym_out   = sym_q;
    assign state_out = rans_q;
`ifdef RANS_DEC_FINAL_CHECK_EN
    assign error = err_q | ((fsm_q == S_FIN) && (rans_q != L_BOUND));
`else
    assign error = err_q;
`endif

endmodule

// File: tb/tb_rans_decoder.sv
// Directed bench for rans_decoder with hand-computed states and symbols.
module tb_rans_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        config_en;
    logic [3:0]  config_select;
    logic [10:0] config_freq;
    logic [9:0]  config_cumul;
    logic        start;
    logic [15:0] num_syms;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;
    logic [31:0] state_out;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

`ifdef RANS_DEC_FINAL_CHECK_EN
    localparam logic FINAL_CHK = 1'b1;
`else
    localparam logic FINAL_CHK = 1'b0;
`endif

    rans_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .config_en(config_en), .config_select(config_select),
        .config_freq(config_freq), .config_cumul(config_cumul),
        .start(start), .num_syms(num_syms),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .state_out(state_out), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " sym_valid"}, sym_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " error"}, error, 0);
        chk({tag, " sym_out"}, sym_out, 0);
        chk({tag, " state_out"}, state_out, 0);
    endtask

    task automatic cfg(input logic [3:0] sel, input logic [10:0] f, input logic [9:0] c);
        config_en = 1'b1; config_select = sel; config_freq = f; config_cumul = c;
        tick();
        config_en = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] n);
        start = 1'b1; num_syms = n;
        tick();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        int n = 0;
        in_data = w; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("push timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_state(input logic [31:0] s);
        for (int i = 3; i >= 0; i--) push_word(s[i*8 +: 8]);
    endtask

    task automatic take_sym(input string tag, input logic [3:0] exp);
        int n = 0;
        while (!sym_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " sym_valid"}, sym_valid, 1);
        chk({tag, " sym_out"}, sym_out, exp);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp_state, input logic exp_err);
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " state_out"}, state_out, exp_state);
        chk({tag, " error"}, error, exp_err);
        tick();
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " busy after"}, busy, 0);
    endtask

    task automatic wait_err(input string tag);
        int  n = 0;
        logic saw_sv = 1'b0;
        while (!error && n < 20) begin
            if (sym_valid) saw_sv = 1'b1;
            tick();
            n++;
        end
        chk({tag, " error"}, error, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " no sym_valid"}, saw_sv, 0);
        tick();
        chk({tag, " sticky"}, error, 1);
    endtask

    task automatic cfg_two();
        cfg(4'd0, 11'd768, 10'd0);
        cfg(4'd1, 11'd256, 10'd768);
    endtask

    initial begin
        rst_n = 1'b0; config_en = 1'b1; config_select = 4'd3; config_freq = 11'd100;
        config_cumul = 10'd5; start = 1'b1; num_syms = 16'd5;
        in_data = 8'h00; in_valid = 1'b0; sym_ready = 1'b0;
        tick(); tick(); tick();
        chk_quiet("reset");
        rst_n = 1'b1; config_en = 1'b0; start = 1'b0;
        tick();

        // Zero tables: lookup must fail on the first DECODE.
        start_job(16'd1);
        chk("load busy", busy, 1);
        chk("load in_ready", in_ready, 1);
        push_word(8'h01);
        push_word(8'h00);
        for (int i = 0; i < 3; i++) tick();
        chk("load stall state", state_out, 32'h0000_0100);
        push_word(8'h03);
        push_word(8'h00);
        wait_err("zero tables");

        // One-word renorm.
        cfg_two();
        start_job(16'd1);
        chk("job2 error cleared", error, 0);
        load_state(32'h0100_0300);
        take_sym("job2", 4'd1);
        chk("job2 renorm in_ready", in_ready, 1);
        chk("job2 next state", state_out, 32'h0040_0000);
        push_word(8'hAB);
        wait_done("job2", 32'h4000_00AB, FINAL_CHK);

        // Symbol stall during EMIT, then renorm.
        start_job(16'd1);
        load_state(32'h0100_0100);
        for (int i = 0; i < 52 && !sym_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall sym_valid", sym_valid, 1);
            chk("stall sym_out", sym_out, 0);
            chk("stall in_ready", in_ready, 0);
            chk("stall state", state_out, 32'h0100_0100);
            tick();
        end
        take_sym("job3", 4'd0);
        chk("job3 next state", state_out, 32'h00C0_0100);
        push_word(8'h55);
        wait_done("job3", 32'hC001_0055, FINAL_CHK);

        // Two symbols, second table, two-word renorm after the rare symbol.
        cfg(4'd1, 11'd255, 10'd768);
        cfg(4'd2, 11'd1, 10'd1023);
        start_job(16'd2);
        load_state(32'h0100_03FF);
        take_sym("multi s0", 4'd2);
        chk("multi next", state_out, 32'h0000_4000);
        push_word(8'h12);
        chk("multi mid renorm", state_out, 32'h0040_0012);
        chk("multi still renorm", in_ready, 1);
        push_word(8'h34);
        take_sym("multi s1", 4'd0);
        wait_done("multi", 32'h3000_0E34, FINAL_CHK);

        // num_syms = 0 with the encoder's initial state.
        start_job(16'd0);
        load_state(32'h0100_0000);
        wait_done("zero count", 32'h0100_0000, 1'b0);

        // Loaded state below L.
        start_job(16'd1);
        load_state(32'h00FF_FFFF);
        wait_err("low load");

        // Only freq[0] configured: slot 768 misses.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        cfg(4'd0, 11'd512, 10'd0);
        start_job(16'd1);
        load_state(32'h0100_0300);
        wait_err("no match");

        // Reset during RENORM, then a clean job.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        cfg_two();
        start_job(16'd1);
        load_state(32'h0100_0100);
        take_sym("pre reset", 4'd0);
        chk("pre reset in_ready", in_ready, 1);
        rst_n = 1'b0;
        tick();
        chk_quiet("mid reset");
        rst_n = 1'b1;
        tick();
        cfg_two();
        start_job(16'd1);
        load_state(32'h0100_0300);
        take_sym("post reset", 4'd1);
        push_word(8'hAB);
        wait_done("post reset", 32'h4000_00AB, FINAL_CHK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
